// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state type and nine's-complement helper
// for the digit-serial BCD adder/subtractor.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // (9 - d) mod 16; invalid digits wrap rather than saturate
  function automatic logic [BCD_W-1:0] nines(
    input logic [BCD_W-1:0] d
  );
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result bundle for bcd_serial_addsub.
// master: start, op, a, b, carry_in -> slave: busy, done, result, carry_out, err.
interface bcd_serial_addsub_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic                    start;
  logic                    op;
  logic [BCD_W*DIGITS-1:0] a;
  logic [BCD_W*DIGITS-1:0] b;
  logic                    carry_in;
  logic                    busy;
  logic                    done;
  logic [BCD_W*DIGITS-1:0] result;
  logic                    carry_out;
  logic                    err;

  modport master (
    output start, op, a, b, carry_in,
    input  busy, done, result, carry_out, err
  );

  modport slave (
    input  start, op, a, b, carry_in,
    output busy, done, result, carry_out, err
  );

endinterface

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit decimal adder with +6 correction.
// Ports: a, b, cin in; sum (4b), cout out.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout
);

  logic [BCD_W:0] s;

  assign s    = {1'b0, a} + {1'b0, b}
              + {{BCD_W{1'b0}}, cin};
  assign cout = s > {1'b0, BCD_MAX};
  assign sum  = cout ? s[BCD_W-1:0] + BCD_CORR
                     : s[BCD_W-1:0];

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD add/subtract, one digit per clock, LSD first.
// Ports: clk, rst_n (async, active-low), bus (slave modport of operand/result bundle).
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_serial_addsub_if.slave  bus
);

  localparam int W  = BCD_W * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    res_q;
  logic            op_q;
  logic            cy_q;
  logic            co_q;
  logic            err_q;
  logic            busy_q;
  logic            done_q;

  logic [BCD_W-1:0] d_a;
  logic [BCD_W-1:0] d_braw;
  logic [BCD_W-1:0] d_b;
  logic [BCD_W-1:0] d_sum;
  logic             d_cout;
  logic             err_in;
  logic             accept;

  assign d_a    = a_q[BCD_W*idx +: BCD_W];
  assign d_braw = b_q[BCD_W*idx +: BCD_W];
  assign d_b    = op_q ? nines(d_braw) : d_braw;

  bcd_digit_adder u_dig (
    .a    (d_a),
    .b    (d_b),
    .cin  (cy_q),
    .sum  (d_sum),
    .cout (d_cout)
  );

  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[BCD_W*i +: BCD_W] > BCD_MAX ||
          bus.b[BCD_W*i +: BCD_W] > BCD_MAX)
        err_in = 1'b1;
    end
  end

  assign accept = bus.start &&
                  (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      op_q   <= 1'b0;
      cy_q   <= 1'b0;
      co_q   <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state  <= RUN;
            idx    <= '0;
            a_q    <= bus.a;
            b_q    <= bus.b;
            op_q   <= bus.op;
            // subtract: carry-in of 1 completes ten's complement
            cy_q   <= bus.op ? ~bus.carry_in
                             : bus.carry_in;
            res_q  <= '0;
            err_q  <= err_in;
            busy_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res_q[BCD_W*idx +: BCD_W] <= d_sum;
          cy_q <= d_cout;
          if (idx == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            co_q   <= d_cout;
          end else begin
            idx <= idx + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.carry_out = co_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub (DIGITS=4): directed scenarios
// plus random operations against an integer-arithmetic decimal model.
module tb_bcd_serial_addsub;

  localparam int D = 4;
  localparam longint MOD = 10000;

  typedef struct {
    logic [4*D-1:0] res;
    logic           co;
    logic           er;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  bcd_serial_addsub_if #(.DIGITS(D)) bus ();

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic longint to_int(input logic [4*D-1:0] v);
    longint r = 0;
    for (int i = D - 1; i >= 0; i--)
      r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input longint n);
    logic [4*D-1:0] v = '0;
    longint t = n;
    for (int i = 0; i < D; i++) begin
      v[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return v;
  endfunction

  function automatic exp_t model(input logic op,
                                 input logic [4*D-1:0] a,
                                 input logic [4*D-1:0] b,
                                 input logic cin);
    exp_t e;
    longint r;
    if (!op) begin
      r = to_int(a) + to_int(b) + longint'(cin);
      e.co = (r >= MOD);
      if (e.co) r = r - MOD;
    end else begin
      r = to_int(a) - to_int(b) - longint'(cin);
      e.co = (r >= 0);
      if (!e.co) r = r + MOD;
    end
    e.res = to_bcd(r);
    e.er = 1'b0;
    for (int i = 0; i < D; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
        e.er = 1'b1;
    return e;
  endfunction

  function automatic logic [4*D-1:0] rand_bcd();
    logic [4*D-1:0] v;
    for (int i = 0; i < D; i++)
      v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got result %0h expected none",
                 bus.result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 64'(bus.result), 64'(e.res));
        check("carry_out", 64'(bus.carry_out), 64'(e.co));
        check("err", 64'(bus.err), 64'(e.er));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic op,
                       input logic [4*D-1:0] a,
                       input logic [4*D-1:0] b,
                       input logic cin);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.carry_in = cin;
    bus.start = 1'b1;
  endtask

  task automatic run_op(input logic op,
                        input logic [4*D-1:0] a,
                        input logic [4*D-1:0] b,
                        input logic cin,
                        input exp_t e);
    int lat;
    int bcnt;
    drive(op, a, b, cin);
    exp_q.push_back(e);
    tick();
    bus.start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!bus.done && lat < 30) begin
      if (bus.busy) bcnt++;
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(D + 1));
    check("busy_cycles", 64'(bcnt), 64'(D));
    check("busy_at_done", 64'(bus.busy), 64'(0));
    tick();
    check("done_pulse", 64'(bus.done), 64'(0));
    tick();
    check("result_held", 64'(bus.result), 64'(e.res));
    check("carry_held", 64'(bus.carry_out), 64'(e.co));
  endtask

  initial begin
    exp_t ex;
    int edges;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.carry_in = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_carry", 64'(bus.carry_out), 64'(0));
    check("rst_err", 64'(bus.err), 64'(0));
    #20 rst_n = 1'b1;
    tick();

    run_op(0, 16'h1234, 16'h5678, 0, model(0, 16'h1234, 16'h5678, 0));
    run_op(0, 16'h9999, 16'h0001, 0, model(0, 16'h9999, 16'h0001, 0));
    run_op(0, 16'h9999, 16'h0000, 1, model(0, 16'h9999, 16'h0000, 1));
    run_op(1, 16'h5000, 16'h1234, 0, model(1, 16'h5000, 16'h1234, 0));
    run_op(1, 16'h1234, 16'h5000, 0, model(1, 16'h1234, 16'h5000, 0));
    run_op(1, 16'h0000, 16'h0000, 1, model(1, 16'h0000, 16'h0000, 1));
    ex = '{res: 16'h0100, co: 1'b0, er: 1'b1};
    run_op(0, 16'h00A0, 16'h0000, 0, ex);
    run_op(0, 16'h0042, 16'h0007, 0, model(0, 16'h0042, 16'h0007, 0));

    // start during RUN is ignored; start in DONE runs back-to-back
    drive(0, 16'h1111, 16'h1111, 0);
    exp_q.push_back(model(0, 16'h1111, 16'h1111, 0));
    tick();
    bus.start = 1'b0;
    edges = 1;
    tick();
    edges++;
    drive(1, 16'h9999, 16'h8888, 1);
    tick();
    edges++;
    bus.start = 1'b0;
    while (!bus.done && edges < 30) begin
      tick();
      edges++;
    end
    check("first_done_edge", 64'(edges), 64'(D + 1));
    drive(0, 16'h0001, 16'h0001, 0);
    exp_q.push_back(model(0, 16'h0001, 16'h0001, 0));
    tick();
    edges++;
    bus.start = 1'b0;
    check("b2b_busy", 64'(bus.busy), 64'(1));
    check("b2b_done_low", 64'(bus.done), 64'(0));
    check("b2b_cleared", 64'(bus.result), 64'(0));
    while (!bus.done && edges < 40) begin
      tick();
      edges++;
    end
    check("b2b_total", 64'(edges), 64'(2 * (D + 1)));
    tick();
    tick();

    // reset during the third RUN cycle
    drive(0, 16'h4321, 16'h1234, 0);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_result", 64'(bus.result), 64'(0));
    check("abort_carry", 64'(bus.carry_out), 64'(0));
    check("abort_err", 64'(bus.err), 64'(0));
    #13 rst_n = 1'b1;
    repeat (8) tick();
    run_op(0, 16'h0505, 16'h0505, 0, model(0, 16'h0505, 16'h0505, 0));

    for (int k = 0; k < 40; k++) begin
      logic op;
      logic cin;
      logic [4*D-1:0] ra;
      logic [4*D-1:0] rb;
      op = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      ra = rand_bcd();
      rb = rand_bcd();
      run_op(op, ra, rb, cin, model(op, ra, rb, cin));
    end

    tick();
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
